// File: rtl/input_fifo_credit.sv
// Per-input flit buffer for a credit-based router: FWFT head flit toward the crossbar,
// one pop per allocator grant, and one registered credit pulse returned upstream per pop.
module input_fifo_credit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  valid_in,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  credit_out,
  output logic                  overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  credit_q;
  logic                  overflow_q;

  logic rd_req;
  logic do_read;
  logic do_write;

  // Several grants aimed at this input in one cycle still pop only one flit.
  assign rd_req   = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign do_read  = rd_req & ~empty;
  assign do_write = valid_in & ~full;

  assign Data_out     = mem_q[rd_ptr_q];
  assign credit_out   = credit_q;
  assign overflow_err = overflow_q;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_read)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_write) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({do_write, do_read})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      credit_q <= do_read;
      if (valid_in && full) overflow_q <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; empty qualifies Data_out, so stale slots are harmless.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= RX;
  end

endmodule

// File: tb/tb_input_fifo_credit.sv
// Self-checking bench for input_fifo_credit: directed scenarios then randomized traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_input_fifo_credit;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] RX;
  logic          valid_in;
  logic          read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [DW-1:0] Data_out;
  logic          empty, full, credit_out, overflow_err;

  input_fifo_credit #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .RX           (RX),
    .valid_in     (valid_in),
    .read_en_N    (read_en_N),
    .read_en_E    (read_en_E),
    .read_en_W    (read_en_W),
    .read_en_S    (read_en_S),
    .read_en_L    (read_en_L),
    .Data_out     (Data_out),
    .empty        (empty),
    .full         (full),
    .credit_out   (credit_out),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] model_q[$];
  logic          exp_credit;
  logic          exp_ovf;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_credits = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One clock: drive inputs, advance the model from pre-edge occupancy, compare after the edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [4:0] rd, input logic rst_n);
    bit pop, push, was_full;
    valid_in  = v;
    RX        = d;
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = rd;
    reset     = rst_n;
    pop      = (rd != 5'b0) && (model_q.size() > 0);
    was_full = (model_q.size() == DEPTH);
    push     = v && !was_full;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_q.delete();
      exp_credit = 1'b0;
      exp_ovf    = 1'b0;
    end else begin
      if (v && was_full) exp_ovf = 1'b1;
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(d);
      exp_credit = pop;
    end
    if (credit_out === 1'b1) n_credits++;
    check("empty", DW'(empty), DW'(model_q.size() == 0));
    check("full", DW'(full), DW'(model_q.size() == DEPTH));
    check("credit_out", DW'(credit_out), DW'(exp_credit));
    check("overflow_err", DW'(overflow_err), DW'(exp_ovf));
    if (model_q.size() > 0) check("Data_out", Data_out, model_q[0]);
  endtask

  initial begin
    int c0;
    exp_credit = 1'b0;
    exp_ovf    = 1'b0;

    // 1. Reset and idle
    cycle(1'b0, '0, 5'b0, 1'b0);
    cycle(1'b0, '0, 5'b0, 1'b0);
    cycle(1'b0, '0, 5'b0, 1'b1);

    // 2. Fill with A1..A4, no reads
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(32'hA0 + i), 5'b0, 1'b1);
    check("full_after_fill", DW'(full), DW'(1));
    check("head_after_fill", Data_out, 32'hA1);

    // 3. Drain with read_en_E for 4 cycles, then one idle cycle for the last credit
    c0 = n_credits;
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 5'b01000, 1'b1);
    cycle(1'b0, '0, 5'b0, 1'b1);
    check("empty_after_drain", DW'(empty), DW'(1));
    check("drain_credits", DW'(n_credits - c0), DW'(4));

    // 4. count=2, simultaneous write and read_en_N for 6 cycles
    cycle(1'b1, 32'hC0, 5'b0, 1'b1);
    cycle(1'b1, 32'hC1, 5'b0, 1'b1);
    c0 = n_credits;
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(32'hD0 + i), 5'b10000, 1'b1);
    cycle(1'b0, '0, 5'b0, 1'b1);
    check("rw_count_holds", DW'(model_q.size()), DW'(2));
    check("rw_credits", DW'(n_credits - c0), DW'(6));
    check("rw_head", Data_out, 32'hD4);

    // 5. Fill, then overflow attempt with a concurrent read_en_L
    cycle(1'b1, 32'hE0, 5'b0, 1'b1);
    cycle(1'b1, 32'hE1, 5'b0, 1'b1);
    cycle(1'b1, 32'h0BAD, 5'b00001, 1'b1);
    check("ovf_set", DW'(overflow_err), DW'(1));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 5'b00001, 1'b1);
      if (!empty) check("no_bad_flit", DW'(Data_out == 32'h0BAD), DW'(0));
    end
    check("ovf_sticky", DW'(overflow_err), DW'(1));

    // 6. Multiple grants at count=3 pop one flit, then reset at count=2
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(32'hF0 + i), 5'b0, 1'b1);
    c0 = n_credits;
    cycle(1'b0, '0, 5'b10010, 1'b1);
    cycle(1'b0, '0, 5'b0, 1'b1);
    check("multi_grant_count", DW'(model_q.size()), DW'(2));
    check("multi_grant_credit", DW'(n_credits - c0), DW'(1));
    cycle(1'b0, '0, 5'b10000, 1'b0);
    c0 = n_credits;
    cycle(1'b0, '0, 5'b10000, 1'b1);
    check("reset_empty", DW'(empty), DW'(1));
    check("reset_no_credit", DW'(n_credits - c0), DW'(0));
    check("reset_ovf_clear", DW'(overflow_err), DW'(0));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic v;
      logic [4:0] rd;
      v  = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 50) ? 5'($urandom) : 5'b0;
      cycle(v, $urandom, rd, ($urandom_range(0, 63) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
